tdc_meas_ctrl: RTL and testbench
================================

Name: tdc_meas_ctrl

Overview:
- Measurement sequencer that sits directly downstream of the delay-line TDC.
- Drives the TDC `start` input and watches the asynchronous `stop` event.
- Counts whole `clk` cycles as the coarse time, then captures the encoder fine code and combines the two into one linear time sample.
- Averages 2^AVG_LOG2 samples per batch and delivers the result on a valid/ready handshake.

Parameters:
- FINE_W, 9, width of the fine code from the TDC encoder.
- COARSE_W, 8, width of the coarse cycle counter.
- FINE_PER_CLK, 300, delay stages per clk period; the fine code is clipped to FINE_PER_CLK-1.
- AVG_LOG2, 2, log2 of samples averaged per batch.
- TIMEOUT, 255, maximum WAIT_STOP cycles before the batch aborts; must be ≤ 2^COARSE_W-1.
- SETTLE_CYC, 2, cycles between the stop edge and fine-code capture.
- RECOVER_CYC, 2, cycles `start_out` stays low between samples so the chain clears.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- meas_req, in, 1, pulse that begins a batch; sampled only in IDLE.
- start_out, out, 1, drives the TDC `start`.
- stop_in, in, 1, asynchronous stop event; same net that clocks the TDC flops.
- fine_code, in, FINE_W, TDC encoder output.
- busy, out, 1, high in every state except IDLE.
- result_data, out, COARSE_W+FINE_W, averaged time in stage units.
- result_err, out, 1, timeout flag, qualified by result_valid.
- result_valid, out, 1, result available.
- result_ready, in, 1, consumer accepts the result.

Behaviour:
- Reset (async, any state): state=IDLE; all counters, accumulator and synchronizer flops = 0; start_out=0, busy=0, result_valid=0, result_err=0, result_data=0.
- stop_in goes through a 2-FF synchronizer. A stop edge (stop_rise) is the synchronized value 1 with its previous value 0. A stop level that is already high never produces an edge.
- SAMPLE_W = COARSE_W+FINE_W. ACC_W = SAMPLE_W+AVG_LOG2.
- FSM states: IDLE, LAUNCH, WAIT_STOP, SETTLE, ACCUM, RECOVER, OUTPUT.
- IDLE:
  - meas_req=1 → LAUNCH.
  - On this transition, clear the accumulator and the sample count.
- LAUNCH: start_out=1; coarse counter=0; → WAIT_STOP after 1 cycle.
- WAIT_STOP:
  - start_out=1; coarse increments every cycle, so the first WAIT_STOP cycle has coarse=0.
  - stop_rise → latch the current coarse value, go to SETTLE. stop_rise takes priority over timeout in the same cycle.
  - Otherwise, coarse==TIMEOUT → OUTPUT with result_err=1, result_data=0; the partial batch is discarded.
- SETTLE:
  - start_out=0 (chain drains).
  - Wait SETTLE_CYC cycles, then register fine_code → ACCUM.
- ACCUM:
  - fine_c = min(fine_code, FINE_PER_CLK-1).
  - sample = coarse*FINE_PER_CLK + fine_c, width SAMPLE_W, no overflow for legal parameters.
  - acc += sample; count++.
  - If count == 2^AVG_LOG2 → OUTPUT with result_data = acc >> AVG_LOG2 (truncating) and result_err=0.
  - Otherwise → RECOVER.
- RECOVER: start_out=0 for RECOVER_CYC cycles → LAUNCH.
- OUTPUT:
  - result_valid=1.
  - result_data and result_err are held stable until result_ready=1.
  - The handshake completes in the cycle result_valid & result_ready → IDLE; result_valid=0 the next cycle.
  - result_ready is ignored outside OUTPUT.
- meas_req is ignored whenever state≠IDLE; there is no queuing.
- busy is registered and equals (state≠IDLE).
- start_out is a registered output with no combinational path from inputs.

Test Plan:
- Reset: assert rst mid-cycle from any state → all outputs 0 immediately, without waiting for a clk edge; FSM in IDLE after release.
- Nominal batch, defaults: meas_req pulse; for each of 4 launches, raise stop_in so the latched coarse=3 and fine_code=100 → one result_valid with result_data=1000, result_err=0.
- Averaging and truncation: the four samples give coarse/fine 3/100, 3/101, 3/102, 3/103 → result_data=1001 (sum 4006>>2).
- Fine clip: coarse=1, fine_code=350 on all 4 samples → each sample 599, result_data=599.
- Timeout: meas_req with stop_in held low, and separately with stop_in held high → result_err=1 and result_data=0. result_valid rises 2+TIMEOUT cycles after leaving IDLE (1 LAUNCH cycle, WAIT_STOP, 1 transition cycle).
- Backpressure: hold result_ready=0 for 10 cycles in OUTPUT while pulsing meas_req → result_data stable, no new batch. Raise ready → result_valid drops the next cycle and busy=0.

Source files
------------

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for a delay-line TDC: launches start, times the stop edge
// in coarse clk cycles plus a clipped fine code, and averages a batch of samples.
module tdc_meas_ctrl #(
    parameter int FINE_W       = 9,
    parameter int COARSE_W     = 8,
    parameter int FINE_PER_CLK = 300,
    parameter int AVG_LOG2     = 2,
    parameter int TIMEOUT      = 255,
    parameter int SETTLE_CYC   = 2,
    parameter int RECOVER_CYC  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         meas_req,
    output logic                         start_out,
    input  logic                         stop_in,
    input  logic [FINE_W-1:0]            fine_code,
    output logic                         busy,
    output logic [COARSE_W+FINE_W-1:0]   result_data,
    output logic                         result_err,
    output logic                         result_valid,
    input  logic                         result_ready
);

    localparam int SAMPLE_W = COARSE_W + FINE_W;
    localparam int ACC_W    = SAMPLE_W + AVG_LOG2;
    localparam int SET_W    = (SETTLE_CYC  > 1) ? $clog2(SETTLE_CYC)  : 1;
    localparam int REC_W    = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [FINE_W-1:0]   FINE_MAX = FINE_W'(FINE_PER_CLK - 1);
    localparam logic [AVG_LOG2:0]   NSAMP    = (AVG_LOG2+1)'(1 << AVG_LOG2);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_STOP, SETTLE, ACCUM, RECOVER, OUTPUT
    } state_t;

    state_t                state;
    logic [COARSE_W-1:0]   coarse;
    logic [COARSE_W-1:0]   coarse_lat;
    logic [FINE_W-1:0]     fine_lat;
    logic [SET_W-1:0]      settle_cnt;
    logic [REC_W-1:0]      rec_cnt;
    logic [AVG_LOG2:0]     cnt;
    logic [ACC_W-1:0]      acc;
    logic                  stop_p0, stop_p1, stop_p2;
    logic                  stop_rise;
    logic [SAMPLE_W-1:0]   sample;
    logic [ACC_W-1:0]      acc_next;
    logic [AVG_LOG2:0]     cnt_next;

    // Codes beyond one clk period of stages are encoder overrun; pin to the last stage.
    function automatic logic [FINE_W-1:0] clip_fine(input logic [FINE_W-1:0] f);
        return (f > FINE_MAX) ? FINE_MAX : f;
    endfunction

    function automatic logic [SAMPLE_W-1:0] mk_sample(input logic [COARSE_W-1:0] c,
                                                      input logic [FINE_W-1:0]   f);
        return SAMPLE_W'(c) * SAMPLE_W'(FINE_PER_CLK) + SAMPLE_W'(clip_fine(f));
    endfunction

    // Stage p0/p1: stop synchronizer; p2 holds the previous synchronized value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_p0 <= 1'b0;
            stop_p1 <= 1'b0;
            stop_p2 <= 1'b0;
        end else begin
            stop_p0 <= stop_in;
            stop_p1 <= stop_p0;
            stop_p2 <= stop_p1;
        end
    end

    assign stop_rise = stop_p1 & ~stop_p2;

    always_comb begin
        sample   = mk_sample(coarse_lat, fine_lat);
        acc_next = acc + ACC_W'(sample);
        cnt_next = cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            coarse       <= '0;
            coarse_lat   <= '0;
            fine_lat     <= '0;
            settle_cnt   <= '0;
            rec_cnt      <= '0;
            cnt          <= '0;
            acc          <= '0;
            start_out    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_err   <= 1'b0;
            result_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (meas_req) begin
                        acc       <= '0;
                        cnt       <= '0;
                        start_out <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    coarse <= '0;
                    state  <= WAIT_STOP;
                end
                WAIT_STOP: begin
                    if (stop_rise) begin
                        coarse_lat <= coarse;
                        settle_cnt <= '0;
                        start_out  <= 1'b0;
                        state      <= SETTLE;
                    end else if (coarse == COARSE_W'(TIMEOUT)) begin
                        start_out    <= 1'b0;
                        result_err   <= 1'b1;
                        result_data  <= '0;
                        result_valid <= 1'b1;
                        state        <= OUTPUT;
                    end else begin
                        coarse <= coarse + 1'b1;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                        fine_lat <= fine_code;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                    if (cnt_next == NSAMP) begin
                        result_data  <= SAMPLE_W'(acc_next >> AVG_LOG2);
                        result_err   <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= OUTPUT;
                    end else begin
                        rec_cnt <= '0;
                        state   <= RECOVER;
                    end
                end
                RECOVER: begin
                    rec_cnt <= rec_cnt + 1'b1;
                    if (rec_cnt == REC_W'(RECOVER_CYC - 1)) begin
                        start_out <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                OUTPUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    start_out    <= 1'b0;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl: nominal, averaging, clipping, timeout,
// backpressure and asynchronous reset, with hand-computed expectations.
module tb_tdc_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        meas_req;
    logic        start_out;
    logic        stop_in;
    logic [8:0]  fine_code;
    logic        busy;
    logic [16:0] result_data;
    logic        result_err;
    logic        result_valid;
    logic        result_ready;

    int checks = 0;
    int errors = 0;

    tdc_meas_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .meas_req     (meas_req),
        .start_out    (start_out),
        .stop_in      (stop_in),
        .fine_code    (fine_code),
        .busy         (busy),
        .result_data  (result_data),
        .result_err   (result_err),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        meas_req = 1'b1;
        tick();
        meas_req = 1'b0;
    endtask

    // Produce one stop edge that latches coarse value c, with fine code f.
    task automatic do_sample(input int c, input int f);
        int n = 0;
        while (!start_out && n < 50) begin
            tick();
            n++;
        end
        check("start_high", start_out, 1);
        repeat (c - 1) @(posedge clk);
        #1;
        stop_in   = 1'b1;
        fine_code = 9'(f);
        n = 0;
        while (start_out && n < 50) begin
            tick();
            n++;
        end
        check("start_low", start_out, 0);
        stop_in = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!result_valid && n < 100) begin
            tick();
            n++;
        end
        check("valid_seen", result_valid, 1);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("hs_valid_drop", result_valid, 0);
        check("hs_busy_drop", busy, 0);
    endtask

    initial begin
        rst          = 1'b1;
        meas_req     = 1'b0;
        stop_in      = 1'b0;
        fine_code    = '0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", start_out, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_err", result_err, 0);
        check("rst_data", result_data, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Nominal batch: coarse 3, fine 100 -> 1000, then backpressure
        pulse_req();
        check("launch_busy", busy, 1);
        for (int i = 0; i < 4; i++) do_sample(3, 100);
        wait_valid();
        check("nom_data", result_data, 1000);
        check("nom_err", result_err, 0);
        for (int i = 0; i < 10; i++) begin
            meas_req = 1'b1;
            tick();
            check("bp_data", result_data, 1000);
            check("bp_valid", result_valid, 1);
            check("bp_start", start_out, 0);
        end
        meas_req = 1'b0;
        handshake();
        repeat (3) tick();
        check("no_queue_busy", busy, 0);

        // Averaging with truncation: (1000+1001+1002+1003)>>2 = 1001
        pulse_req();
        for (int i = 0; i < 4; i++) do_sample(3, 100 + i);
        wait_valid();
        check("avg_data", result_data, 1001);
        check("avg_err", result_err, 0);
        handshake();

        // Fine clip: 1*300 + min(350,299) = 599
        pulse_req();
        for (int i = 0; i < 4; i++) do_sample(1, 350);
        wait_valid();
        check("clip_data", result_data, 599);
        handshake();

        // Timeout with stop low: valid rises 257 edges after leaving IDLE
        pulse_req();
        repeat (256) @(posedge clk);
        #1;
        check("to_lo_early", result_valid, 0);
        tick();
        check("to_lo_valid", result_valid, 1);
        check("to_lo_err", result_err, 1);
        check("to_lo_data", result_data, 0);
        handshake();

        // Timeout with stop already high: no edge is ever seen
        stop_in = 1'b1;
        repeat (5) tick();
        pulse_req();
        repeat (256) @(posedge clk);
        #1;
        check("to_hi_early", result_valid, 0);
        tick();
        check("to_hi_valid", result_valid, 1);
        check("to_hi_err", result_err, 1);
        check("to_hi_data", result_data, 0);
        handshake();
        stop_in = 1'b0;
        repeat (4) tick();

        // Async reset mid-cycle while holding a result in OUTPUT
        pulse_req();
        for (int i = 0; i < 4; i++) do_sample(2, 50);
        wait_valid();
        check("pre_rst_data", result_data, 650);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", result_valid, 0);
        check("arst_data", result_data, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);

        // Async reset mid-cycle during WAIT_STOP
        pulse_req();
        repeat (3) tick();
        check("ws_start", start_out, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ws_start", start_out, 0);
        check("arst_ws_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        check("ws_idle_busy", busy, 0);
        check("ws_idle_start", start_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
